// File: rtl/tl_a_throttle_queue_if.sv
// A-channel enqueue/dequeue bundle for the throttle queue, plus its D-retire
// strobe and occupancy/outstanding status.
interface tl_a_throttle_queue_if #(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
);
  logic                          enq_valid;
  logic                          enq_ready;
  logic [2:0]                    enq_opcode;
  logic [2:0]                    enq_param;
  logic [1:0]                    enq_size;
  logic                          enq_source;
  logic [29:0]                   enq_address;
  logic [3:0]                    enq_mask;
  logic [31:0]                   enq_data;
  logic                          enq_corrupt;

  logic                          deq_valid;
  logic                          deq_ready;
  logic [2:0]                    deq_opcode;
  logic [2:0]                    deq_param;
  logic [1:0]                    deq_size;
  logic                          deq_source;
  logic [29:0]                   deq_address;
  logic [3:0]                    deq_mask;
  logic [31:0]                   deq_data;
  logic                          deq_corrupt;

  logic                          d_fire;
  logic [$clog2(DEPTH):0]        count;
  logic [$clog2(MAX_INFLIGHT):0] inflight;
  logic                          err_underflow;

  modport slave (
    input  enq_valid, enq_opcode, enq_param, enq_size, enq_source,
           enq_address, enq_mask, enq_data, enq_corrupt, deq_ready, d_fire,
    output enq_ready, deq_valid, deq_opcode, deq_param, deq_size, deq_source,
           deq_address, deq_mask, deq_data, deq_corrupt,
           count, inflight, err_underflow
  );

  modport master (
    output enq_valid, enq_opcode, enq_param, enq_size, enq_source,
           enq_address, enq_mask, enq_data, enq_corrupt, deq_ready, d_fire,
    input  enq_ready, deq_valid, deq_opcode, deq_param, deq_size, deq_source,
           deq_address, deq_mask, deq_data, deq_corrupt,
           count, inflight, err_underflow
  );
endinterface

// File: rtl/tl_a_throttle_queue.sv
// Ring-buffered TileLink-UL A-channel stage that stops issuing beats while
// MAX_INFLIGHT requests await their D response.
module tl_a_throttle_queue #(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  tl_a_throttle_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic        source;
    logic [29:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_beat_t;

  a_beat_t         mem [DEPTH];
  a_beat_t         enq_beat;
  a_beat_t         head;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [IW-1:0]   inflight;
  logic            err_underflow;
  logic            full, empty, throttle, enq_fire, deq_fire;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign throttle = (inflight == IW'(MAX_INFLIGHT));
  assign enq_fire = q.enq_valid & ~full;
  assign deq_fire = ~empty & ~throttle & q.deq_ready;

  assign enq_beat = {q.enq_opcode, q.enq_param, q.enq_size, q.enq_source,
                     q.enq_address, q.enq_mask, q.enq_data, q.enq_corrupt};
  // Head entry is always visible so fields hold steady across a stall.
  assign head     = mem[rptr];

  assign q.enq_ready     = ~full;
  assign q.deq_valid     = ~empty & ~throttle;
  assign q.deq_opcode    = head.opcode;
  assign q.deq_param     = head.param;
  assign q.deq_size      = head.size;
  assign q.deq_source    = head.source;
  assign q.deq_address   = head.address;
  assign q.deq_mask      = head.mask;
  assign q.deq_data      = head.data;
  assign q.deq_corrupt   = head.corrupt;
  assign q.count         = count;
  assign q.inflight      = inflight;
  assign q.err_underflow = err_underflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq_fire) begin
      mem[wptr] <= enq_beat;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + AW'(1);
      if (deq_fire) rptr <= rptr + AW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A lone D retire with nothing outstanding is a protocol error, not a wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({deq_fire, q.d_fire})
        2'b10: inflight <= inflight + IW'(1);
        2'b01: begin
          if (inflight == '0) err_underflow <= 1'b1;
          else                inflight      <= inflight - IW'(1);
        end
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_a_throttle_queue.sv
// Directed bench for tl_a_throttle_queue: beats are scoreboarded on enqueue
// and checked in order by a monitor; status is checked at fixed points.
module tb_tl_a_throttle_queue;
  localparam int DEPTH        = 2;
  localparam int MAX_INFLIGHT = 4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic        source;
    logic [29:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } beat_t;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clock = ~clock;

  tl_a_throttle_queue_if #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) q ();

  tl_a_throttle_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clock(clock),
    .reset(reset),
    .q    (q)
  );

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t deq_beat();
    return {q.deq_opcode, q.deq_param, q.deq_size, q.deq_source,
            q.deq_address, q.deq_mask, q.deq_data, q.deq_corrupt};
  endfunction

  function automatic beat_t mk(input int i);
    beat_t b;
    b.opcode  = 3'(i % 8);
    b.param   = 3'((i + 3) % 8);
    b.size    = 2'(i % 4);
    b.source  = i[0];
    b.address = 30'(32'h100 + i * 16);
    b.mask    = 4'(15 - (i % 16));
    b.data    = 32'hA500_0000 + 32'(i);
    b.corrupt = i[1];
    return b;
  endfunction

  task automatic drive(input beat_t b);
    q.enq_opcode  = b.opcode;
    q.enq_param   = b.param;
    q.enq_size    = b.size;
    q.enq_source  = b.source;
    q.enq_address = b.address;
    q.enq_mask    = b.mask;
    q.enq_data    = b.data;
    q.enq_corrupt = b.corrupt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer a beat until accepted (bounded); returns #1 after the accepting edge.
  task automatic push(input beat_t b);
    int n;
    n = 0;
    drive(b);
    q.enq_valid = 1'b1;
    while (!q.enq_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got enq_ready=0 for %0d cycles expected 1", n);
    end else begin
      @(posedge clock);
      sb.push_back(b);
      #1;
    end
    q.enq_valid = 1'b0;
  endtask

  task automatic do_reset(input int pending);
    chk("sb_pending", 76'(sb.size()), 76'(pending));
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
  endtask

  // Monitor: every accepted output beat must match the oldest expected beat.
  always @(negedge clock) begin
    beat_t e;
    if (!reset && q.deq_valid && q.deq_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", deq_beat());
      end else begin
        e = sb.pop_front();
        chk("beat_order", deq_beat(), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic  prev, cur;
    q.enq_valid = 1'b0;
    q.deq_ready = 1'b0;
    q.d_fire    = 1'b0;
    drive('0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_deq_valid", q.deq_valid, 1'b0);
    chk("rst_enq_ready", q.enq_ready, 1'b1);
    chk("rst_count", q.count, 0);
    chk("rst_inflight", q.inflight, 0);
    chk("rst_err", q.err_underflow, 1'b0);
    chk("rst_fields", deq_beat(), '0);

    // Single Get: 1-cycle latency, no flow-through
    b = '0;
    b.opcode  = 3'd4;
    b.address = 30'h10;
    q.deq_ready = 1'b1;
    drive(b);
    q.enq_valid = 1'b1;
    chk("no_flow_through", q.deq_valid, 1'b0);
    @(posedge clock);
    sb.push_back(b);
    #1;
    q.enq_valid = 1'b0;
    chk("lat1_valid", q.deq_valid, 1'b1);
    chk("lat1_addr", q.deq_address, 30'h10);
    chk("lat1_opcode", q.deq_opcode, 3'd4);
    step();
    chk("t1_count", q.count, 0);
    chk("t1_inflight", q.inflight, 1);
    do_reset(0);

    // Fill with backpressure, stall stability, full+deq same cycle
    q.deq_ready = 1'b0;
    push(mk(1));
    push(mk(2));
    chk("full_count", q.count, 2);
    chk("full_enq_ready", q.enq_ready, 1'b0);
    drive(mk(3));
    q.enq_valid = 1'b1;
    step();
    chk("stall_valid", q.deq_valid, 1'b1);
    chk("stall_head", deq_beat(), mk(1));
    q.deq_ready = 1'b1;
    chk("full_deq_enq_ready", q.enq_ready, 1'b0);
    push(mk(3));
    step();
    chk("drain_count", q.count, 0);
    chk("drain_inflight", q.inflight, 3);
    do_reset(0);

    // Streaming: one in, one out per cycle across pointer wraps
    q.deq_ready = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(mk(10 + i));
      q.enq_valid = 1'b1;
      q.d_fire    = prev;
      chk("stream_enq_ready", q.enq_ready, 1'b1);
      if (i > 0) chk("stream_deq_valid", q.deq_valid, 1'b1);
      cur = q.deq_valid && q.deq_ready;
      @(posedge clock);
      sb.push_back(mk(10 + i));
      #1;
      prev = cur;
    end
    q.enq_valid = 1'b0;
    q.d_fire    = prev;
    cur = q.deq_valid;
    step();
    q.d_fire = cur;
    step();
    q.d_fire = 1'b0;
    chk("stream_count", q.count, 0);
    chk("stream_inflight", q.inflight, 0);
    chk("stream_err", q.err_underflow, 1'b0);
    do_reset(0);

    // Throttle at MAX_INFLIGHT, released by one D retire
    q.deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(mk(20 + i));
    chk("thr_inflight", q.inflight, 4);
    chk("thr_count", q.count, 1);
    chk("thr_valid", q.deq_valid, 1'b0);
    step();
    chk("thr_hold_valid", q.deq_valid, 1'b0);
    q.d_fire = 1'b1;
    step();
    q.d_fire = 1'b0;
    chk("thr_rel_inflight", q.inflight, 3);
    chk("thr_rel_valid", q.deq_valid, 1'b1);
    step();
    chk("thr_end_inflight", q.inflight, 4);
    chk("thr_end_count", q.count, 0);
    do_reset(0);

    // deq_fire and d_fire together leave inflight unchanged
    q.deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(30 + i));
    chk("both_pre_inflight", q.inflight, 2);
    chk("both_pre_valid", q.deq_valid, 1'b1);
    q.d_fire = 1'b1;
    step();
    q.d_fire = 1'b0;
    chk("both_inflight", q.inflight, 2);
    chk("both_err", q.err_underflow, 1'b0);
    do_reset(0);

    // Underflow is sticky until reset
    q.d_fire = 1'b1;
    step();
    q.d_fire = 1'b0;
    chk("uf_err", q.err_underflow, 1'b1);
    chk("uf_inflight", q.inflight, 0);
    q.deq_ready = 1'b1;
    push(mk(40));
    step();
    q.d_fire = 1'b1;
    step();
    q.d_fire = 1'b0;
    chk("uf_after_inflight", q.inflight, 0);
    chk("uf_sticky", q.err_underflow, 1'b1);
    do_reset(0);
    chk("uf_cleared", q.err_underflow, 1'b0);

    // Asynchronous reset mid-cycle with count=2, inflight=3
    q.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(mk(50 + i));
    q.deq_ready = 1'b0;
    push(mk(54));
    chk("ar_pre_count", q.count, 2);
    chk("ar_pre_inflight", q.inflight, 3);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_count", q.count, 0);
    chk("ar_inflight", q.inflight, 0);
    chk("ar_deq_valid", q.deq_valid, 1'b0);
    chk("ar_enq_ready", q.enq_ready, 1'b1);
    chk("ar_fields", deq_beat(), '0);
    chk("ar_pending", 76'(sb.size()), 76'(2));
    sb.delete();
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tl_a_throttle_queue.md
# tl_a_throttle_queue

Buffered TileLink-UL A-channel stage that sits directly upstream of the A-channel monitor/assert wrapper and feeds its A-channel inputs. It stores up to DEPTH A beats in a ring buffer and presents them downstream in order. It also tracks outstanding requests (A beats issued minus D responses retired) and withholds further A beats once MAX_INFLIGHT requests are outstanding. A D response retired while nothing is outstanding sets a sticky error flag.

## Interface
- DEPTH, 2, number of buffered A beats; power of two, at least 2
- MAX_INFLIGHT, 4, maximum outstanding requests; at least 1
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  reset, asynchronous and active-high
- enq_valid  in  1  upstream A beat valid
- enq_ready  out  1  buffer can accept a beat
- enq_opcode / enq_param  in  3 / 3  A opcode / param
- enq_size  in  2  log2 of the transfer byte count
- enq_source  in  1  source ID
- enq_address  in  30  byte address
- enq_mask  in  4  byte lanes
- enq_data  in  32  write data
- enq_corrupt  in  1  corrupt flag
- deq_valid  out  1  A beat valid toward the monitor/slave
- deq_ready  in  1  downstream accepts
- deq_opcode, deq_param, deq_size, deq_source, deq_address, deq_mask, deq_data, deq_corrupt  out  3, 3, 2, 1, 30, 4, 32, 1  head-entry fields
- d_fire  in  1  one D response retired this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding requests
- err_underflow  out  1  sticky: D retired with inflight==0

## Operation
- Storage: DEPTH-entry register array.
  - wptr and rptr are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked explicitly; full means count==DEPTH, empty means count==0.
- enq_fire = enq_valid & enq_ready, with enq_ready = ~full.
  - enq_ready does not depend on deq_ready; there is no pipe-through when full.
  - On enq_fire, write all enq fields to entry[wptr] and increment wptr.
- throttle = (inflight == MAX_INFLIGHT).
- deq_valid = ~empty & ~throttle.
- deq_* always drive entry[rptr], including while deq_valid is low.
- deq_fire = deq_valid & deq_ready. On deq_fire, increment rptr.
- count update: +1 on enq_fire only; -1 on deq_fire only; unchanged when both occur or neither.
- inflight update:
  - +1 on deq_fire only; -1 on d_fire only; unchanged when both occur in the same cycle.
  - If d_fire arrives while inflight==0 (and no deq_fire that cycle): inflight stays 0 and err_underflow sets to 1.
  - err_underflow clears only on reset.
- No flow-through: an empty buffer cannot pass a beat in the same cycle it is enqueued.
- The queue does not inspect or modify payload fields; it carries them unchanged.

## Timing
- Reset (asynchronous assert, synchronous release via clock):
  - wptr, rptr, count, inflight, err_underflow all 0.
  - All storage entries 0, so every deq_* output is 0.
  - deq_valid=0, enq_ready=1.
- Reset asserted mid-transfer discards all buffered beats and outstanding counts immediately, with no clock edge required.
- Latency:
  - A beat enqueued at edge N appears on deq_valid after edge N (visible in cycle N+1), provided not throttled.
  - Minimum enq-to-deq latency is 1 cycle.
- Throughput: one enqueue and one dequeue per cycle when neither empty nor full.
  - Full + deq_fire in the same cycle: enq_ready is still 0 that cycle; it rises the next cycle.
  - Empty + enq_fire: deq_valid stays 0 that cycle.
- Throttle:
  - deq_valid drops combinationally in the cycle inflight reaches MAX_INFLIGHT.
  - When d_fire lowers inflight at edge N, deq_valid may rise in cycle N+1.
- Pointer wrap: after DEPTH writes, wptr returns to 0 with no bubble.
- Handshake rule: while deq_valid=1 and deq_ready=0, deq_valid and every deq_* field stay stable, unless reset is asserted.

## Test plan
- Reset, then enqueue address 0x0000_0010 with opcode 4 (Get) while deq_ready=1 -> deq_valid=1 exactly one cycle later with address 0x10 and opcode 4; count returns to 0; inflight=1.
- DEPTH=2, deq_ready=0, push 3 beats -> enq_ready=0 after the second, count=2. Raise deq_ready -> beats exit in order (1, 2), then the third is accepted; 6 push/pop cycles exercise pointer wrap.
- MAX_INFLIGHT=4, deq_ready=1, d_fire=0, push 5 beats -> 4 dequeued, inflight=4, deq_valid=0 with count=1. Pulse d_fire once -> deq_valid=1 next cycle, 5th beat exits, inflight returns to 4.
- With inflight=2, assert deq_fire and d_fire in the same cycle -> inflight stays 2, err_underflow=0.
- From reset, pulse d_fire -> err_underflow=1 and inflight=0. A later normal transfer leaves err_underflow at 1 until reset.
- With count=2 and inflight=3, assert reset asynchronously between edges -> immediately count=0, inflight=0, deq_valid=0, enq_ready=1, and all deq_* fields are 0.
